fp_divider: RTL and testbench

Sequential IEEE-754 single-precision divider for the vector processor FPU. It is the inverse operation of the FPU's combinational multiplier.
- Computes `out = a / b` by iterative restoring division, one quotient bit per cycle.
- Uses a start/busy/done handshake so that vector lanes can issue divisions and collect results.
- Rounding is truncation (round toward zero).

---
 rtl/fp_divider_if.sv | 28 ++
 rtl/fp_divider.sv | 166 ++++++++++++++++
 tb/tb_fp_divider.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_divider_if
//  Description : Start/busy/done handshake bundle for the sequential
//                single-precision divider. The issuing lane is the master,
//                the divider is the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, out, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, out, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/fp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : fp_divider
//  Description : IEEE-754 single-precision divider, out = a / b, using
//                restoring division (one quotient bit per clock) and
//                truncating rounding. Inf/NaN, zero and divide-by-zero
//                operands are resolved on the accepting edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_divider (
    input  wire logic     clk,
    input  wire logic     rst,
    fp_divider_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]  LAST_BIT  = 5'd24;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;

    state_t             state;
    logic [4:0]         cnt;
    logic [25:0]        rem;
    logic [24:0]        quo;
    logic [23:0]        mb;
    logic               sign;
    logic signed [9:0]  exp_acc;

    logic               busy_flag;
    logic               done_pulse;
    logic [31:0]        result;
    logic               dbz_flag;

    // Operand decode used on the accepting edge
    logic               in_sign;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic               accept;

    assign in_sign = bus.a[31] ^ bus.b[31];
    assign ea      = bus.a[30:23];
    assign eb      = bus.b[30:23];
    assign accept  = bus.start && ((state == IDLE) || (state == DONE));

    // One restoring-division step: trial subtract, keep on success, shift
    logic               ge;
    logic [25:0]        diff;
    logic [25:0]        kept;
    logic [25:0]        rem_next;

    assign ge       = (rem >= {2'b00, mb});
    assign diff     = rem - {2'b00, mb};
    assign kept     = ge ? diff : rem;
    assign rem_next = {kept[24:0], 1'b0};

    // Normalisation: quotient lies in [2^23, 2^25), so at most one right shift
    logic signed [9:0]  e_fin;
    logic [22:0]        frac;
    logic [31:0]        norm_result;

    // Pick mantissa window and final exponent, then clamp to Inf or zero
    always_comb begin
        e_fin       = exp_acc;
        frac        = quo[22:0];
        norm_result = {sign, 31'h0};
        if (quo[24]) begin
            e_fin = exp_acc;
            frac  = quo[23:1];
        end else begin
            e_fin = exp_acc - 10'sd1;
            frac  = quo[22:0];
        end
        if (e_fin >= 10'sd255) begin
            norm_result = {sign, EXP_MAX, 23'h0};
        end else if (e_fin <= 10'sd0) begin
            norm_result = {sign, 31'h0};
        end else begin
            norm_result = {sign, e_fin[7:0], frac};
        end
    end

    // Control FSM and datapath registers; all outputs come straight from flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            rem        <= 26'd0;
            quo        <= 25'd0;
            mb         <= 24'd0;
            sign       <= 1'b0;
            exp_acc    <= 10'sd0;
            busy_flag  <= 1'b0;
            done_pulse <= 1'b0;
            result     <= 32'h0;
            dbz_flag   <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        sign <= in_sign;
                        if ((ea == EXP_MAX) || (eb == EXP_MAX)) begin
                            result     <= QNAN;
                            dbz_flag   <= 1'b0;
                            done_pulse <= 1'b1;
                            state      <= DONE;
                        end else if (eb == 8'd0) begin
                            result     <= {in_sign, EXP_MAX, 23'h0};
                            dbz_flag   <= 1'b1;
                            done_pulse <= 1'b1;
                            state      <= DONE;
                        end else if (ea == 8'd0) begin
                            result     <= {in_sign, 31'h0};
                            dbz_flag   <= 1'b0;
                            done_pulse <= 1'b1;
                            state      <= DONE;
                        end else begin
                            // Leading one restored; the result register keeps
                            // the previous answer until NORM overwrites it
                            rem       <= {2'b01, bus.a[22:0]};
                            mb        <= {1'b1, bus.b[22:0]};
                            quo       <= 25'd0;
                            cnt       <= LAST_BIT;
                            exp_acc   <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                            busy_flag <= 1'b1;
                            state     <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= {quo[23:0], ge};
                    if (cnt == 5'd0) begin
                        state <= NORM;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                NORM: begin
                    result     <= norm_result;
                    dbz_flag   <= 1'b0;
                    done_pulse <= 1'b1;
                    busy_flag  <= 1'b0;
                    state      <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_flag;
    assign bus.done        = done_pulse;
    assign bus.out         = result;
    assign bus.div_by_zero = dbz_flag;

endmodule
`default_nettype wire

// File: tb/tb_fp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_divider
//  Description : Scoreboard bench for fp_divider. Issued operations push the
//                expected result and completion cycle; a monitor pops and
//                compares whenever done is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    fp_divider_if bus ();

    fp_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] out;
        logic        dbz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_seen  = 0;
    logic [31:0] last_out = 32'h0;
    logic        last_dbz = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value-level division with integer arithmetic, then the
    // truncate / clamp rules. Returns {div_by_zero, out}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea;
        int          eb;
        int          e;
        longint      ma;
        longint      mb;
        longint      q;
        logic [22:0] frac;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {1'b0, 32'h7FC00000};
        if (eb == 0)                return {1'b1, s, 8'hFF, 23'h0};
        if (ea == 0)                return {1'b0, s, 31'h0};
        ma = longint'(8388608) + longint'(a[22:0]);
        mb = longint'(8388608) + longint'(b[22:0]);
        q  = (ma * longint'(16777216)) / mb;
        e  = ea - eb + 127;
        if (q >= longint'(16777216)) begin
            q = q / 2;
        end else begin
            e = e - 1;
        end
        frac = q[22:0];
        if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
        if (e <= 0)   return {1'b0, s, 31'h0};
        return {1'b0, s, 8'(e), frac};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
               (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
    endfunction

    // Called at the negedge where start is driven; acceptance is the next posedge
    task automatic push(input logic [31:0] a, input logic [31:0] b, input string name);
        exp_t        e;
        logic [32:0] m;
        m      = model(a, b);
        e.out  = m[31:0];
        e.dbz  = m[32];
        e.cyc  = cyc + (is_special(a, b) ? 1 : 27);
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input string name);
        int guard;
        guard = 0;
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_issue_wait_busy"}, {31'h0, bus.busy}, 32'h0);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        push(a, b, name);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_drain_pending"}, 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    // Monitor: compare on done, check missing completions and output holding
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_out = 32'h0;
                last_dbz = 1'b0;
            end else if (bus.done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: out %h dbz %b with nothing outstanding", bus.out, bus.div_by_zero);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_out"}, bus.out, e.out);
                    chk({e.name, "_dbz"}, {31'h0, bus.div_by_zero}, {31'h0, e.dbz});
                    chk({e.name, "_latency_cycle"}, 32'(cyc), 32'(e.cyc));
                    chk({e.name, "_busy_at_done"}, {31'h0, bus.busy}, 32'h0);
                end
                last_out = bus.out;
                last_dbz = bus.div_by_zero;
            end else begin
                if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    e = sb.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s_timeout: no done by cycle %0d required at %0d", e.name, cyc, e.cyc);
                end
                chk("out_hold", bus.out, last_out);
                chk("dbz_hold", {31'h0, bus.div_by_zero}, {31'h0, last_dbz});
            end
        end
    end

    initial begin
        int busy_cnt;
        int guard;
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start = 1'b0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_out",  bus.out, 32'h0);
        chk("rst_dbz",  {31'h0, bus.div_by_zero}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 6.0 / 2.0 with busy-duration measurement
        issue(32'h40C00000, 32'h40000000, "six_div_two");
        busy_cnt = 0;
        guard    = 0;
        while (bus.busy && guard < 60) begin
            busy_cnt++;
            guard++;
            @(negedge clk);
        end
        chk("six_div_two_busy_cycles", 32'(busy_cnt), 32'd26);
        wait_idle("six_div_two");

        // Directed values, specials and range clamps (issued back-to-back)
        issue(32'h3F800000, 32'h40400000, "one_div_three");
        issue(32'hBFC00000, 32'h3F000000, "neg_1p5_div_0p5");
        issue(32'hBF800000, 32'h00000000, "div_by_zero");
        issue(32'h00000000, 32'h40000000, "zero_dividend");
        issue(32'h7F800000, 32'h3F800000, "inf_dividend");
        issue(32'h3F800000, 32'h7FC00001, "nan_divisor");
        issue(32'h7F000000, 32'h00800000, "overflow");
        issue(32'h00800000, 32'h7F000000, "underflow");
        wait_idle("directed");

        // Start pulses during a running division are ignored
        issue(32'h40C00000, 32'h40000000, "ignore_start");
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40400000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        bus.start = 1'b1; bus.a = 32'hBF800000; bus.b = 32'h00000000;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("ignore_start");

        // Start held through done: next operation accepted in the DONE cycle
        bus.start = 1'b1; bus.a = 32'h40C00000; bus.b = 32'h40000000;
        push(32'h40C00000, 32'h40000000, "held_first");
        @(negedge clk);
        bus.a = 32'h3F800000; bus.b = 32'h40400000;
        guard = 0;
        while (!bus.done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        push(32'h3F800000, 32'h40400000, "held_second");
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("held_start");

        // Asynchronous reset mid-division
        issue(32'h40C00000, 32'h3FC00000, "reset_abort");
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        chk("abort_done", {31'h0, bus.done}, 32'h0);
        chk("abort_out",  bus.out, 32'h0);
        chk("abort_dbz",  {31'h0, bus.div_by_zero}, 32'h0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = done_seen;
        repeat (30) @(negedge clk);
        chk("abort_no_done", 32'(done_seen - seen), 32'h0);
        issue(32'h40C00000, 32'h40000000, "after_reset");
        wait_idle("after_reset");

        // Randomised operands, mostly normal with occasional specials
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 9) != 0) ra[30:23] = 8'($urandom_range(1, 254));
            if ($urandom_range(0, 9) != 0) rb[30:23] = 8'($urandom_range(1, 254));
            issue(ra, rb, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
